// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  // Control states of the unit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One radix-4 Booth digit per multiply iteration, one quotient bit per divide iteration.
  localparam int MULT_ITERS = 16;
  localparam int DIV_ITERS  = 32;

  // Most negative 32-bit value; the only dividend that can overflow a divide.
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Radix-4 Booth digit values: 0, +A, +2A, -A, -2A.
  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_PA   = 3'd1,
    BOOTH_P2A  = 3'd2,
    BOOTH_MA   = 3'd3,
    BOOTH_M2A  = 3'd4
  } booth_e;

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: maps multiplier bits {2i+1, 2i, 2i-1} to a digit
// plus the negate/double controls used to build the addend.
module booth_recode
  import multdiv_pkg::*;
(
  input  logic [2:0] bits_i,
  output booth_e     digit_o,
  output logic       neg_o,
  output logic       dbl_o
);

  // Digit table plus derived addend controls.
  always_comb begin
    digit_o = BOOTH_ZERO;
    case (bits_i)
      3'b001, 3'b010: digit_o = BOOTH_PA;
      3'b011:         digit_o = BOOTH_P2A;
      3'b100:         digit_o = BOOTH_M2A;
      3'b101, 3'b110: digit_o = BOOTH_MA;
      default:        digit_o = BOOTH_ZERO;
    endcase
    neg_o = (digit_o == BOOTH_MA) || (digit_o == BOOTH_M2A);
    dbl_o = (digit_o == BOOTH_P2A) || (digit_o == BOOTH_M2A);
  end

endmodule

// File: rtl/iter_multdiv.sv
// Iterative signed 32-bit multiply (radix-4 Booth, 16 cycles) and divide
// (non-restoring, 32 cycles) sharing one 34-bit add/subtract datapath.
module iter_multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             running
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  // Accumulator: hi holds the upper partial product (multiply) or the
  // signed remainder (divide); lo collects product low bits or quotient bits.
  logic [33:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d, rdy_q, rdy_d, run_q, run_d;

  logic        start, start_div;
  logic [32:0] b_ext;
  logic [3:0]  mult_idx;
  logic [2:0]  booth_bits;
  booth_e      digit;
  logic        digit_neg, digit_dbl;
  logic [33:0] a_sx, mult_y;
  logic [31:0] a_mag, b_mag;
  logic [4:0]  div_idx;
  logic        div_bit;
  logic [33:0] add_x, add_y, add_sum;
  logic        add_sub;
  logic [33:0] hi_step;
  logic [31:0] lo_step;
  logic [63:0] product;
  logic [31:0] fin_result;
  logic        fin_exc;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;   // multiply wins a tie

  // Booth window: counter runs 16..1, so digit index is (16 - cnt) mod 16.
  assign b_ext      = {b_q, 1'b0};
  assign mult_idx   = 4'd0 - cnt_q[3:0];
  assign booth_bits = b_ext[{1'b0, mult_idx, 1'b0} +: 3];

  booth_recode u_booth (
    .bits_i  (booth_bits),
    .digit_o (digit),
    .neg_o   (digit_neg),
    .dbl_o   (digit_dbl)
  );

  // Operand magnitudes for divide; |INT_MIN| fits as unsigned 0x80000000.
  assign a_sx    = {{2{a_q[31]}}, a_q};
  assign a_mag   = a_q[31] ? (32'd0 - a_q) : a_q;
  assign b_mag   = b_q[31] ? (32'd0 - b_q) : b_q;
  // Dividend bits enter MSB first: counter runs 32..1 so bit index is cnt-1.
  assign div_idx = cnt_q[4:0] - 5'd1;
  assign div_bit = a_mag[div_idx];

  // Shared adder operand selection for the current iteration.
  always_comb begin
    mult_y  = digit_dbl ? {a_sx[32:0], 1'b0} : a_sx;
    add_x   = hi_q;
    add_y   = '0;
    add_sub = 1'b0;
    if (is_div_q) begin
      // Non-restoring: subtract divisor while remainder is non-negative.
      add_x   = {hi_q[32:0], div_bit};
      add_y   = {2'b00, b_mag};
      add_sub = ~hi_q[33];
    end else if (digit != BOOTH_ZERO) begin
      add_y   = mult_y;
      add_sub = digit_neg;
    end
    add_sum = add_x + (add_y ^ {34{add_sub}}) + {33'd0, add_sub};
  end

  // Per-iteration accumulator update and end-of-operation result shaping.
  always_comb begin
    if (is_div_q) begin
      hi_step = add_sum;
      lo_step = {lo_q[30:0], ~add_sum[33]};
    end else begin
      hi_step = {{2{add_sum[33]}}, add_sum[33:2]};
      lo_step = {add_sum[1:0], lo_q[31:2]};
    end
    product = {hi_step[31:0], lo_step};
    if (is_div_q) begin
      if (b_q == 32'd0) begin
        fin_result = 32'd0;
        fin_exc    = 1'b1;
      end else begin
        fin_result = (a_q[31] ^ b_q[31]) ? (32'd0 - lo_step) : lo_step;
        fin_exc    = (a_q == INT_MIN) && (b_q == 32'hFFFF_FFFF);
      end
    end else begin
      fin_result = product[31:0];
      fin_exc    = product[63:32] != {32{product[31]}};
    end
  end

  // Next-state, iteration control and registered-output next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_BUSY;
          is_div_d = start_div;
          a_d      = data_operandA;
          b_d      = data_operandB;
          hi_d     = '0;
          lo_d     = '0;
          cnt_d    = start_div ? 6'(DIV_ITERS) : 6'(MULT_ITERS);
        end
      end
      ST_BUSY: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d  = ST_DONE;
          result_d = fin_result;
          exc_d    = fin_exc;
          rdy_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    run_d = (state_d == ST_BUSY);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      run_q    <= run_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign running        = run_q;

endmodule

// File: tb/tb_iter_multdiv.sv
// Self-checking bench for iter_multdiv: directed corner cases with literal
// expectations, then randomized traffic compared every cycle to a
// latency/arithmetic reference model.
module tb_iter_multdiv;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] op_a = '0, op_b = '0;
  logic        ctrl_mult = 1'b0, ctrl_div = 1'b0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, running;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  iter_multdiv #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_MULT      (ctrl_mult),
    .ctrl_DIV       (ctrl_div),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .running        (running)
  );

  always #5 clock = ~clock;

  // Arithmetic reference: {exception, result}.
  function automatic logic [32:0] ref_fn(input logic mul, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q;
    if (mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {(p != longint'($signed(p[31:0]))), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  // Reference model: an op takes 16/32 edges, starts ignored while one is in flight.
  logic        m_run = 1'b0, m_rdy = 1'b0, m_exc = 1'b0;
  logic [31:0] m_res = '0;
  logic [32:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_run  <= 1'b0;
      m_rdy  <= 1'b0;
      m_res  <= '0;
      m_exc  <= 1'b0;
      m_left <= 0;
    end else begin
      m_rdy <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_run <= 1'b0;
          m_rdy <= 1'b1;
          {m_exc, m_res} <= m_pend;
        end
      end else if (ctrl_mult || ctrl_div) begin
        m_pend <= ref_fn(ctrl_mult, op_a, op_b);
        m_left <= ctrl_mult ? 16 : 32;
        m_run  <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_running", 32'(running), 32'(m_run));
      chk("cyc_rdy", 32'(data_resultRDY), 32'(m_rdy));
      chk("cyc_result", data_result, m_res);
      chk("cyc_exception", 32'(data_exception), 32'(m_exc));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Waits (bounded) for the RDY pulse; lat counts edges after the start edge.
  task automatic wait_done(input int poke_at, output int lat, output int run_cnt);
    bit seen;
    seen    = 1'b0;
    lat     = 0;
    run_cnt = int'(running);
    for (int n = 1; n <= 60 && !seen; n++) begin
      if (n == poke_at) begin
        ctrl_div = 1'b1;
        op_a = $urandom;
        op_b = $urandom;
      end
      tick();
      ctrl_div = 1'b0;
      if (data_resultRDY) begin
        seen = 1'b1;
        lat  = n;
      end else if (running) begin
        run_cnt++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got no RDY within 60 cycles expected one");
    end
  endtask

  task automatic do_op(input string nm, input logic mul, input logic dv,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic exp_e, input int exp_lat,
                       input int poke_at);
    int lat, run_cnt;
    op_a = a; op_b = b; ctrl_mult = mul; ctrl_div = dv;
    tick();
    ctrl_mult = 1'b0; ctrl_div = 1'b0;
    wait_done(poke_at, lat, run_cnt);
    $display("op %s a=%h b=%h result=%h exc=%b latency=%0d", nm, a, b, data_result, data_exception, lat);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_running_cycles"}, 32'(run_cnt), 32'(exp_lat));
    chk({nm, "_result"}, data_result, exp_r);
    chk({nm, "_exception"}, 32'(data_exception), 32'(exp_e));
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, run_cnt, extra;

    // Reset state.
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_result", data_result, 32'h0);
    chk("reset_exception", 32'(data_exception), 32'h0);
    chk("reset_rdy", 32'(data_resultRDY), 32'h0);
    chk("reset_running", 32'(running), 32'h0);

    // Directed multiply / divide corners.
    do_op("mul_7x-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 16, 0);
    do_op("mul_ovf_2^32", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1, 16, 0);
    do_op("mul_intmin_x-1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 16, 0);
    do_op("div_-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 32, 0);
    do_op("div_100/-10", 0, 1, 32'd100, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 0, 32, 0);
    do_op("div_5/0", 0, 1, 32'd5, 32'd0, 32'h0, 1, 32, 0);
    do_op("div_intmin/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 32, 0);
    do_op("both_6x3", 1, 1, 32'd6, 32'd3, 32'd18, 0, 16, 0);

    // A divide request during BUSY must be ignored: no second RDY.
    do_op("div_20/4_poked", 0, 1, 32'd20, 32'd4, 32'd5, 0, 32, 5);
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (data_resultRDY) extra++;
    end
    chk("ignored_start_no_rdy", 32'(extra), 32'h0);

    // Back-to-back: next start sampled on the DONE cycle.
    op_a = 32'd2; op_b = 32'd3; ctrl_mult = 1'b1;
    tick();
    ctrl_mult = 1'b0;
    wait_done(0, lat, run_cnt);
    chk("b2b_first_latency", 32'(lat), 32'd16);
    chk("b2b_first_result", data_result, 32'd6);
    op_a = 32'd4; op_b = 32'd5; ctrl_mult = 1'b1;
    tick();
    ctrl_mult = 1'b0;
    chk("b2b_running_next", 32'(running), 32'h1);
    wait_done(0, lat, run_cnt);
    $display("op b2b_4x5 result=%h latency_from_E17=%0d", data_result, lat);
    chk("b2b_second_latency", 32'(lat), 32'd16);
    chk("b2b_second_result", data_result, 32'd20);

    // Mid-operation reset discards the divide.
    op_a = 32'd1000; op_b = 32'd7; ctrl_div = 1'b1;
    tick();
    ctrl_div = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_result", data_result, 32'h0);
    chk("midreset_exception", 32'(data_exception), 32'h0);
    chk("midreset_rdy", 32'(data_resultRDY), 32'h0);
    chk("midreset_running", 32'(running), 32'h0);
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (data_resultRDY) extra++;
    end
    chk("midreset_no_rdy", 32'(extra), 32'h0);
    do_op("mul_3x3_after_reset", 1, 0, 32'd3, 32'd3, 32'd9, 0, 16, 0);

    // Randomized traffic; per-cycle compare checks against the model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 399) == 0);
      ctrl_mult = ($urandom_range(0, 3) == 0);
      ctrl_div  = ($urandom_range(0, 3) == 0);
      op_a      = rand_opnd();
      op_b      = rand_opnd();
      tick();
    end
    reset = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0;
    for (int n = 0; n < 40; n++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
